exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- Multicycle exception sequencer that produces the Excp and EPC operands consumed by the PC source select stage.
- On an exception event it:
  - latches the faulting PC into EPC;
  - records the cause;
  - fetches the handler byte from the cause-specific memory vector;
  - presents the byte zero-extended on Excp_out with a one-cycle ready pulse, so control can select PCSource=5 next.

Parameters:
- MEM_LATENCY, 1, memory read wait cycles after the request cycle (0..15).
- VEC_OPCODE, 253, byte address of the handler for a nonexistent opcode.
- VEC_OVERFLOW, 254, byte address of the handler for ALU overflow.
- VEC_DIV0, 255, byte address of the handler for divide by zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exc_opcode  in  1  nonexistent-opcode event, sampled in IDLE.
- exc_overflow  in  1  overflow event, sampled in IDLE.
- exc_div0  in  1  divide-by-zero event, sampled in IDLE.
- PC_out  in  32  current PC value (already PC+4).
- Mem_data_in  in  8  low byte of the memory read data.
- mem_req  out  1  memory read request; high during REQ and WAIT.
- mem_addr  out  32  vector address; valid while mem_req=1, 0 otherwise.
- EPC_out  out  32  faulting instruction address.
- Excp_out  out  32  zero-extended handler byte.
- cause_out  out  2  0=none, 1=opcode, 2=overflow, 3=div0.
- busy  out  1  high in every state except IDLE.
- excp_ready  out  1  one-cycle pulse; Excp_out is valid.
- excp_lost  out  1  sticky flag: an event arrived while busy.

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state goes to IDLE;
  - all outputs and internal registers are cleared to 0;
  - an in-flight sequence is aborted with no ready pulse.
- State machine states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If any exc_* input is 1 at a rising edge, move to REQ.
  - At that same edge:
    - cause_out <= highest priority active event, priority opcode > overflow > div0;
    - EPC_out <= PC_out - 4, modulo 2^32 (PC_out=0 gives 0xFFFFFFFC);
    - the latency counter is loaded with MEM_LATENCY.
- REQ:
  - mem_req=1, mem_addr = vector for the latched cause.
  - If MEM_LATENCY=0: sample Mem_data_in at the end of this cycle and go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - mem_req=1, mem_addr held at the vector.
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1:
    - Excp_out <= {24'b0, Mem_data_in};
    - go to DONE.
- DONE: excp_ready=1 for exactly this cycle, then go to IDLE.
- Latency: an event in cycle 0 gives excp_ready in cycle MEM_LATENCY+2.
  - Example, MEM_LATENCY=1: REQ in cycle 1, WAIT in cycle 2, DONE in cycle 3.
- EPC_out, Excp_out and cause_out hold until the next accepted event or reset.
- An event accepted in the cycle right after DONE is legal: IDLE samples it normally.
- Events in REQ, WAIT or DONE are dropped.
  - excp_lost is set to 1 and stays set until reset.
  - Latched values are not disturbed.
- Multiple simultaneous events: only the highest priority event is serviced; the others are not flagged as lost.
- Event inputs are level-sampled. Control must deassert them before the cycle after DONE, or the event retriggers.

Decomposition:
- Shared package, exception_pkg:
  - state encoding, 2 bits;
  - cause codes, 2 bits;
  - the three vector default constants.
- No sub-module required. The latency counter is an inline 4-bit down-counter.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> all outputs are 0 and busy=0.
- Overflow, MEM_LATENCY=1:
  - Stimulus: PC_out=0x00000024, exc_overflow pulse, memory returns 0x8C at address 254.
  - Required: EPC_out=0x00000020, cause_out=2, mem_addr=254 for 2 cycles, Excp_out=0x0000008C, excp_ready pulses in cycle 3 only.
- Simultaneous events: exc_opcode=1 and exc_div0=1 with PC_out=0x00000010 -> cause_out=1, mem_addr=253, EPC_out=0x0000000C, excp_lost=0.
- Event while busy: exc_div0 during WAIT -> excp_lost=1, cause_out and EPC_out unchanged, sequence completes normally.
- Reset mid-op: reset=0 during WAIT -> mem_req=0, no excp_ready, outputs are 0, next event is serviced normally.
- Wrap and zero latency:
  - Stimulus: MEM_LATENCY=0, PC_out=0x00000000, exc_div0, memory returns 0xFF.
  - Required: EPC_out=0xFFFFFFFC, Excp_out=0x000000FF, excp_ready in cycle 2.

Source files
------------

// File: rtl/exception_pkg.sv
// Shared encodings for the exception sequencer: FSM states, cause codes and
// the default handler vector byte addresses.
package exception_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_OPCODE   = 2'd1,
    CAUSE_OVERFLOW = 2'd2,
    CAUSE_DIV0     = 2'd3
  } cause_t;

  localparam int unsigned DEF_VEC_OPCODE   = 253;
  localparam int unsigned DEF_VEC_OVERFLOW = 254;
  localparam int unsigned DEF_VEC_DIV0     = 255;

endpackage

// File: rtl/exception_unit.sv
// Multicycle exception sequencer: latches EPC and cause, fetches the handler
// byte from the cause vector and presents it with a one-cycle ready pulse.
module exception_unit
  import exception_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned VEC_OPCODE   = DEF_VEC_OPCODE,
  parameter int unsigned VEC_OVERFLOW = DEF_VEC_OVERFLOW,
  parameter int unsigned VEC_DIV0     = DEF_VEC_DIV0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] PC_out,
  input  logic [7:0]  Mem_data_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] EPC_out,
  output logic [31:0] Excp_out,
  output logic [1:0]  cause_out,
  output logic        busy,
  output logic        excp_ready,
  output logic        excp_lost
);

  state_t      state, next_state;
  cause_t      cause, event_cause;
  logic [3:0]  lat_cnt;
  logic [31:0] epc, excp, vector;
  logic        lost, any_event, capture;

  assign any_event = exc_opcode | exc_overflow | exc_div0;

  always_comb begin
    event_cause = CAUSE_NONE;
    if (exc_opcode)        event_cause = CAUSE_OPCODE;
    else if (exc_overflow) event_cause = CAUSE_OVERFLOW;
    else if (exc_div0)     event_cause = CAUSE_DIV0;
  end

  always_comb begin
    vector = 32'd0;
    case (cause)
      CAUSE_OPCODE:   vector = 32'(VEC_OPCODE);
      CAUSE_OVERFLOW: vector = 32'(VEC_OVERFLOW);
      CAUSE_DIV0:     vector = 32'(VEC_DIV0);
      default:        vector = 32'd0;
    endcase
  end

  // With zero latency the byte is already on the bus during the request cycle.
  assign capture = ((state == REQ) && (MEM_LATENCY == 0)) ||
                   ((state == WAIT) && (lat_cnt == 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_event) next_state = REQ;
      REQ:     next_state = (MEM_LATENCY == 0) ? DONE : WAIT;
      WAIT:    if (capture) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause   <= CAUSE_NONE;
      epc     <= 32'd0;
      excp    <= 32'd0;
      lat_cnt <= 4'd0;
      lost    <= 1'b0;
    end else begin
      if (state == IDLE && any_event) begin
        cause   <= event_cause;
        epc     <= PC_out - 32'd4;
        lat_cnt <= 4'(MEM_LATENCY);
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (capture) excp <= {24'b0, Mem_data_in};
      // Events outside IDLE are dropped but remembered until reset.
      if (state != IDLE && any_event) lost <= 1'b1;
    end
  end

  assign mem_req    = (state == REQ) || (state == WAIT);
  assign mem_addr   = mem_req ? vector : 32'd0;
  assign busy       = (state != IDLE);
  assign excp_ready = (state == DONE);
  assign EPC_out    = epc;
  assign Excp_out   = excp;
  assign cause_out  = cause;
  assign excp_lost  = lost;

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: one instance with one wait cycle,
// one with zero wait cycles, and a scoreboard of expected handler results.
module tb_exception_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_op, a_ov, a_dz, a_req, a_busy, a_ready, a_lost;
  logic [31:0] a_pc, a_addr, a_epc, a_excp;
  logic [7:0]  a_mdata;
  logic [1:0]  a_cause;
  logic        b_op, b_ov, b_dz, b_req, b_busy, b_ready, b_lost;
  logic [31:0] b_pc, b_addr, b_epc, b_excp;
  logic [7:0]  b_mdata;
  logic [1:0]  b_cause;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] excp;
    logic [31:0] vec;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] addr);
    case (addr)
      32'd253: return 8'h3A;
      32'd254: return 8'h8C;
      32'd255: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Off-request cycles drive junk so a mistimed sample shows up.
  assign a_mdata = a_req ? mem_byte(a_addr) : 8'hEE;
  assign b_mdata = b_req ? mem_byte(b_addr) : 8'hEE;

  exception_unit #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .exc_opcode(a_op), .exc_overflow(a_ov), .exc_div0(a_dz),
    .PC_out(a_pc), .Mem_data_in(a_mdata),
    .mem_req(a_req), .mem_addr(a_addr), .EPC_out(a_epc), .Excp_out(a_excp),
    .cause_out(a_cause), .busy(a_busy), .excp_ready(a_ready), .excp_lost(a_lost)
  );

  exception_unit #(.MEM_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .exc_opcode(b_op), .exc_overflow(b_ov), .exc_div0(b_dz),
    .PC_out(b_pc), .Mem_data_in(b_mdata),
    .mem_req(b_req), .mem_addr(b_addr), .EPC_out(b_epc), .Excp_out(b_excp),
    .cause_out(b_cause), .busy(b_busy), .excp_ready(b_ready), .excp_lost(b_lost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic setEvents(input bit sel, input logic op, input logic ov, input logic dz);
    if (sel) begin b_op = op; b_ov = ov; b_dz = dz; end
    else     begin a_op = op; a_ov = ov; a_dz = dz; end
  endtask

  task automatic applyStimulus(input bit sel, input logic op, input logic ov,
                               input logic dz, input logic [31:0] pc, input bit push);
    exp_t e;
    if (op)      begin e.cause = 2'd1; e.vec = 32'd253; end
    else if (ov) begin e.cause = 2'd2; e.vec = 32'd254; end
    else         begin e.cause = 2'd3; e.vec = 32'd255; end
    e.epc  = pc - 32'd4;
    e.excp = {24'b0, mem_byte(e.vec)};
    e.lat  = sel ? 0 : 1;
    if (sel) b_pc = pc; else a_pc = pc;
    setEvents(sel, op, ov, dz);
    if (push) sb.push_back(e);
  endtask

  task automatic checkCleared(input bit sel, input string tag);
    checkOutput({tag, "_epc"},   sel ? b_epc   : a_epc,   32'd0);
    checkOutput({tag, "_excp"},  sel ? b_excp  : a_excp,  32'd0);
    checkOutput({tag, "_cause"}, 32'(sel ? b_cause : a_cause), 32'd0);
    checkOutput({tag, "_busy"},  32'(sel ? b_busy  : a_busy),  32'd0);
    checkOutput({tag, "_ready"}, 32'(sel ? b_ready : a_ready), 32'd0);
    checkOutput({tag, "_lost"},  32'(sel ? b_lost  : a_lost),  32'd0);
    checkOutput({tag, "_req"},   32'(sel ? b_req   : a_req),   32'd0);
    checkOutput({tag, "_addr"},  sel ? b_addr  : a_addr,  32'd0);
  endtask

  // Runs one sequence to its ready pulse; inject raises exc_div0 in that cycle.
  task automatic waitReady(input bit sel, input int inject);
    int   n = 0;
    int   req_cycles = 0;
    bit   seen = 1'b0;
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    while (!seen && n < 40) begin
      tick();
      n++;
      setEvents(sel, 1'b0, 1'b0, n == inject);
      if (sel ? b_req : a_req) begin
        req_cycles++;
        checkOutput("mem_addr", sel ? b_addr : a_addr, e.vec);
      end
      if (sel ? b_ready : a_ready) seen = 1'b1;
    end
    checkOutput("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("ready_cycle", 32'(n), 32'(e.lat + 2));
      checkOutput("req_cycles",  32'(req_cycles), 32'(e.lat + 1));
      checkOutput("cause",  32'(sel ? b_cause : a_cause), 32'(e.cause));
      checkOutput("epc",    sel ? b_epc  : a_epc,  e.epc);
      checkOutput("excp",   sel ? b_excp : a_excp, e.excp);
    end
    tick();
    checkOutput("ready_pulse_len", 32'(sel ? b_ready : a_ready), 32'd0);
    checkOutput("idle_busy", 32'(sel ? b_busy : a_busy), 32'd0);
    checkOutput("idle_addr", sel ? b_addr : a_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    a_pc = 32'd0; b_pc = 32'd0;
    setEvents(1'b0, 1'b0, 1'b0, 1'b0);
    setEvents(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles, then released into a quiet idle.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checkCleared(1'b0, "reset_a");
    checkCleared(1'b1, "reset_b");

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0024, 1'b1);
    waitReady(1'b0, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1);
    waitReady(1'b0, 0);
    checkOutput("simul_lost", 32'(a_lost), 32'd0);

    // Divide-by-zero raised during WAIT must be dropped and flagged.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b1);
    waitReady(1'b0, 2);
    checkOutput("busy_lost", 32'(a_lost), 32'd1);
    checkOutput("busy_cause_held", 32'(a_cause), 32'd2);
    checkOutput("busy_epc_held", a_epc, 32'h0000_00FC);

    // Reset asserted mid-sequence aborts without a ready pulse.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b0);
    tick();
    setEvents(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midop_req", 32'(a_req), 32'd1);
    tick();
    checkOutput("midop_wait_busy", 32'(a_busy), 32'd1);
    reset = 1'b0;
    #1;
    checkCleared(1'b0, "midop_reset");
    tick();
    checkOutput("midop_no_ready1", 32'(a_ready), 32'd0);
    tick();
    checkOutput("midop_no_ready2", 32'(a_ready), 32'd0);
    reset = 1'b1;
    tick();
    checkCleared(1'b0, "midop_after");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 1'b1);
    waitReady(1'b0, 0);
    checkOutput("midop_lost_clear", 32'(a_lost), 32'd0);

    // Zero-latency instance: PC wrap, then an event in the cycle after DONE.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    waitReady(1'b1, 0);
    checkOutput("epc_wrap", b_epc, 32'hFFFF_FFFC);
    checkOutput("excp_ff", b_excp, 32'h0000_00FF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 1'b1);
    waitReady(1'b1, 0);
    checkOutput("b2b_lost", 32'(b_lost), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
